// File: rtl/mult_arbiter.sv
// mult_arbiter: arbitrates two requesters onto one shared iterative multiplier.
// Define MULT_ARB_RR_EN for round-robin grants; otherwise req0 has fixed priority.
`ifndef WORD
`define WORD 64
`endif

module mult_arbiter #(
    parameter int SIZE = `WORD
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req0_valid,
    input  logic [SIZE-1:0] req0_a,
    input  logic [SIZE-1:0] req0_b,
    input  logic [1:0]      req0_mode,
    output logic            req0_ack,
    input  logic            req1_valid,
    input  logic [SIZE-1:0] req1_a,
    input  logic [SIZE-1:0] req1_b,
    input  logic [1:0]      req1_mode,
    output logic            req1_ack,
    output logic            resp_valid,
    output logic            resp_id,
    output logic [SIZE-1:0] resp_result,
    output logic            busy,
    output logic [SIZE-1:0] mult_multiplicand,
    output logic [SIZE-1:0] mult_multiplier,
    output logic [1:0]      mult_mode,
    output logic            mult_start,
    input  logic [SIZE-1:0] mult_result,
    input  logic            mult_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [SIZE-1:0] lat_a;
    logic [SIZE-1:0] lat_b;
    logic [1:0]      lat_mode;
    logic            lat_id;
    logic            grant_any;
    logic            grant_id;

    // Acks are gated by reset_n so a request is never acknowledged during reset.
    assign grant_any = reset_n && (state == IDLE) && (req0_valid || req1_valid);

`ifdef MULT_ARB_RR_EN
    logic last_id;

    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_id;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_id <= 1'b1;
        end else if (grant_any) begin
            last_id <= grant_id;
        end
    end
`else
    assign grant_id = ~req0_valid;
`endif

    assign req0_ack = grant_any && !grant_id;
    assign req1_ack = grant_any && grant_id;

    assign mult_multiplicand = lat_a;
    assign mult_multiplier   = lat_b;
    assign mult_mode         = lat_mode;

    // mult_start stays high in ISSUE until the multiplier is ready to accept it,
    // so an abandoned operation still running after reset is never disturbed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            mult_start  <= 1'b0;
            resp_valid  <= 1'b0;
            busy        <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            lat_a       <= '0;
            lat_b       <= '0;
            lat_mode    <= 2'b00;
            lat_id      <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        lat_a      <= grant_id ? req1_a : req0_a;
                        lat_b      <= grant_id ? req1_b : req0_b;
                        lat_mode   <= grant_id ? req1_mode : req0_mode;
                        lat_id     <= grant_id;
                        mult_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mult_ready) begin
                        mult_start <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (mult_ready) begin
                        resp_result <= mult_result;
                        resp_id     <= lat_id;
                        resp_valid  <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mult_start <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: randomized self-checking bench with a behavioural multiplier
// (SIZE/2 busy cycles) and an arithmetic product reference.
module tb_mult_arbiter;

    localparam int SIZE = 64;
    localparam int LAT  = SIZE / 2 + 3;
`ifdef MULT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            req0_valid, req1_valid;
    logic [SIZE-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]      req0_mode, req1_mode;
    logic            req0_ack, req1_ack;
    logic            resp_valid, resp_id;
    logic [SIZE-1:0] resp_result;
    logic            busy;
    logic [SIZE-1:0] mult_multiplicand, mult_multiplier;
    logic [1:0]      mult_mode;
    logic            mult_start;
    logic [SIZE-1:0] mult_result = '0;
    logic            mult_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mult_arbiter #(.SIZE(SIZE)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode), .req0_ack(req0_ack),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode), .req1_ack(req1_ack),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result), .busy(busy),
        .mult_multiplicand(mult_multiplicand), .mult_multiplier(mult_multiplier),
        .mult_mode(mult_mode), .mult_start(mult_start),
        .mult_result(mult_result), .mult_ready(mult_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [SIZE-1:0] ref_product(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                                    input logic [1:0] mode);
        logic [2*SIZE-1:0] p;
        case (mode)
            2'b01: begin
                p = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};
                return p[2*SIZE-1:SIZE];
            end
            2'b10: begin
                p = {{SIZE{a[SIZE-1]}}, a} * {{SIZE{b[SIZE-1]}}, b};
                return p[2*SIZE-1:SIZE];
            end
            default: return a * b;
        endcase
    endfunction

    // Shared multiplier: accepts start when ready, busy for SIZE/2 cycles, no reset.
    logic [SIZE-1:0] m_a = '0, m_b = '0;
    logic [1:0]      m_mode = 2'b00;
    int              m_cnt = 0;
    always @(posedge clk) begin
        if (mult_ready && mult_start) begin
            mult_ready <= 1'b0;
            m_cnt      <= SIZE / 2;
            m_a        <= mult_multiplicand;
            m_b        <= mult_multiplier;
            m_mode     <= mult_mode;
        end else if (!mult_ready) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mult_ready  <= 1'b1;
                mult_result <= ref_product(m_a, m_b, m_mode);
            end
        end
    end

    task automatic transact(input bit id, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                            input logic [1:0] mode, output int t_ack, output int t_start, output int t_resp,
                            output logic r_id, output logic [SIZE-1:0] r_res,
                            output logic [SIZE-1:0] s_a, output logic [SIZE-1:0] s_b,
                            output logic [1:0] s_mode);
        t_ack = -1; t_start = -1; t_resp = -1;
        r_id = 1'bx; r_res = 'x; s_a = 'x; s_b = 'x; s_mode = 'x;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_mode = mode; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_mode = mode; end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (id ? (req1_ack && !req0_ack) : (req0_ack && !req1_ack)) begin
                t_ack = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (t_ack < 0) return;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mult_start && t_start < 0) begin
                t_start = cyc; s_a = mult_multiplicand; s_b = mult_multiplier; s_mode = mult_mode;
            end
            if (resp_valid) begin
                t_resp = cyc; r_id = resp_id; r_res = resp_result;
                break;
            end
        end
    endtask

    task automatic issue_and_verify(input string tag, input bit id, input logic [SIZE-1:0] a,
                                    input logic [SIZE-1:0] b, input logic [1:0] mode,
                                    input logic [SIZE-1:0] expected);
        int ta, ts, tr;
        logic rid;
        logic [SIZE-1:0] res, sa, sb;
        logic [1:0] sm;
        transact(id, a, b, mode, ta, ts, tr, rid, res, sa, sb, sm);
        checks++;
        if (ta < 0 || tr < 0) begin
            errors++; $display("[TB] FAIL %s timeout: ack cycle %0d resp cycle %0d, both required", tag, ta, tr);
        end
        checks++;
        if ((ts - ta) !== 1) begin
            errors++; $display("[TB] FAIL %s start_latency: got %0d required 1", tag, ts - ta);
        end
        checks++;
        if ((tr - ta) !== LAT) begin
            errors++; $display("[TB] FAIL %s resp_latency: got %0d required %0d", tag, tr - ta, LAT);
        end
        checks++;
        if (rid !== id) begin
            errors++; $display("[TB] FAIL %s resp_id: got %0b required %0b", tag, rid, id);
        end
        checks++;
        if (res !== expected) begin
            errors++; $display("[TB] FAIL %s resp_result: got %h required %h", tag, res, expected);
        end
        checks++;
        if ({sa, sb, sm} !== {a, b, mode}) begin
            errors++; $display("[TB] FAIL %s mult_operands: got %h/%h/%b required %h/%h/%b", tag, sa, sb, sm, a, b, mode);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_mode = 2'b00;
        req1_a = '0; req1_b = '0; req1_mode = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, resp_valid, mult_start, resp_id, req0_ack, req1_ack} !== 6'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b required 000000",
                               {busy, resp_valid, mult_start, resp_id, req0_ack, req1_ack});
        end
        checks++;
        if (resp_result !== '0) begin
            errors++; $display("[TB] FAIL reset_result: got %h required 0", resp_result);
        end
        checks++;
        if ({mult_multiplicand, mult_multiplier, mult_mode} !== '0) begin
            errors++; $display("[TB] FAIL reset_operands: got %h/%h/%b required 0", mult_multiplicand, mult_multiplier, mult_mode);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        issue_and_verify("mul_3x5", 1'b0, 64'd3, 64'd5, 2'b00, 64'd15);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_result !== 64'd15) begin
            errors++; $display("[TB] FAIL resp_pulse_hold: got valid=%b result=%h required valid=0 result=f", resp_valid, resp_result);
        end
        issue_and_verify("smulh_neg2x3", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF);
        issue_and_verify("umulh_msbx4", 1'b0, 64'h8000_0000_0000_0000, 64'd4, 2'b01, 64'h0000_0000_0000_0002);
    endtask

    task automatic test_back_to_back();
        int t_resp1, t_ack2;
        bit early;
        logic b2;
        logic [SIZE-1:0] res1, res2;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 64'd9; req0_b = 64'd9; req0_mode = 2'b00;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req0_ack) break;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 64'd12; req1_b = 64'd12; req1_mode = 2'b00;
        t_resp1 = -1; early = 1'b0; res1 = 'x; res2 = 'x; b2 = 1'bx; t_ack2 = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req1_ack) early = 1'b1;
            if (resp_valid) begin t_resp1 = cyc; res1 = resp_result; break; end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (req1_ack) begin t_ack2 = cyc; b2 = busy; break; end
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid) begin res2 = resp_result; break; end
        end
        checks++;
        if (early !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_ack_while_busy: got 1 required 0");
        end
        checks++;
        if (res1 !== 64'd81) begin
            errors++; $display("[TB] FAIL b2b_first_result: got %h required 51", res1);
        end
        checks++;
        if ((t_ack2 - t_resp1) !== 1 || t_ack2 < 0) begin
            errors++; $display("[TB] FAIL b2b_gap: got %0d cycles required 1", t_ack2 - t_resp1);
        end
        checks++;
        if (b2 !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_busy_at_ack: got %b required 0", b2);
        end
        checks++;
        if (res2 !== 64'd144) begin
            errors++; $display("[TB] FAIL b2b_second_result: got %h required 90", res2);
        end
    endtask

    task automatic test_random();
        logic [SIZE-1:0] a, b;
        logic [1:0] mode;
        bit id;
        for (int n = 0; n < 8; n++) begin
            id = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            mode = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) a = '1;
            if ($urandom_range(0, 3) == 0) b = {1'b1, {(SIZE-1){1'b0}}};
            issue_and_verify("random", id, a, b, mode, ref_product(a, b, mode));
        end
    endtask

    task automatic test_reset_abort();
        int resp_seen, n_start, t_ack;
        bit started, accepted, dropped, got;
        logic [SIZE-1:0] res;
        logic rid;
        resp_seen = 0; n_start = 0; t_ack = -1;
        started = 1'b0; accepted = 1'b0; dropped = 1'b0; got = 1'b0; res = 'x; rid = 1'bx;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 64'd100; req0_b = 64'd200; req0_mode = 2'b00;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req0_ack) break;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        if (resp_valid) resp_seen++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        req0_valid = 1'b1; req0_a = 64'd7; req0_b = 64'd6; req0_mode = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
            if (req0_ack) begin t_ack = cyc; break; end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mult_start) begin
                started = 1'b1;
                n_start++;
                if (mult_ready) accepted = 1'b1;
            end else if (started && !accepted) begin
                dropped = 1'b1;
            end
            if (resp_valid) begin got = 1'b1; res = resp_result; rid = resp_id; break; end
        end
        checks++;
        if (resp_seen !== 0) begin
            errors++; $display("[TB] FAIL abort_no_resp: got %0d responses required 0", resp_seen);
        end
        checks++;
        if (t_ack < 0) begin
            errors++; $display("[TB] FAIL abort_new_ack: got none required ack after reset");
        end
        checks++;
        if (dropped !== 1'b0 || accepted !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_start_hold: got dropped=%b accepted=%b required 0/1", dropped, accepted);
        end
        checks++;
        if (n_start < 2) begin
            errors++; $display("[TB] FAIL abort_start_cycles: got %0d required >=2 while multiplier busy", n_start);
        end
        checks++;
        if (got !== 1'b1 || res !== 64'd42 || rid !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_result: got valid=%b id=%b result=%h required 1/0/2a", got, rid, res);
        end
    endtask

    task automatic test_reset_hold();
        @(posedge clk); #1;
        reset_n = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd11; req0_b = 64'd13; req0_mode = 2'b00;
        req1_valid = 1'b1; req1_a = 64'd17; req1_b = 64'd19; req1_mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req0_ack !== 1'b0 || req1_ack !== 1'b0) begin
                errors++; $display("[TB] FAIL hold_ack cycle %0d: got %b%b required 00", i, req0_ack, req1_ack);
            end
        end
        checks++;
        if ({busy, resp_valid, mult_start, resp_id} !== 4'b0) begin
            errors++; $display("[TB] FAIL hold_ctrl: got %b required 0000", {busy, resp_valid, mult_start, resp_id});
        end
        checks++;
        if (resp_result !== '0) begin
            errors++; $display("[TB] FAIL hold_result: got %h required 0", resp_result);
        end
        checks++;
        if ({mult_multiplicand, mult_multiplier, mult_mode} !== '0) begin
            errors++; $display("[TB] FAIL hold_operands: got %h/%h/%b required 0", mult_multiplicand, mult_multiplier, mult_mode);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // Runs straight after test_reset_hold with both requesters still valid.
    task automatic test_arbitration();
        bit last, want, g, both, seen;
        logic [SIZE-1:0] res, expected;
        last = 1'b1;
        for (int op = 0; op < 4; op++) begin
            seen = 1'b0; g = 1'b0; both = 1'b0; res = 'x;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (req0_ack || req1_ack) begin
                    seen = 1'b1; g = req1_ack; both = req0_ack && req1_ack;
                    break;
                end
            end
            want = RR ? ~last : 1'b0;
            checks++;
            if (!seen || g !== want || both) begin
                errors++; $display("[TB] FAIL arb_grant op %0d: got seen=%b id=%b both=%b required id=%b",
                                   op, seen, g, both, want);
            end
            last = g;
            expected = g ? 64'd323 : 64'd143;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (resp_valid) begin res = resp_result; break; end
            end
            checks++;
            if (res !== expected) begin
                errors++; $display("[TB] FAIL arb_result op %0d: got %h required %h", op, res, expected);
            end
            checks++;
            if (resp_id !== g) begin
                errors++; $display("[TB] FAIL arb_resp_id op %0d: got %b required %b", op, resp_id, g);
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_reset_hold();
        test_arbitration();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
